instr_fetch_unit: RTL and testbench

//  Producer side of the controller's instruction interface: fetches 32-bit ARM words from

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build macro consumed by the fetch unit: FETCH_PERF_EN.
package fetch_pkg;

  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ARM_PC_OFS = 32'd8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // One prefetch slot: the fetched word tagged with its own address.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry prefetch FIFO of {pc,instr} with synchronous clear.
// Latency: push visible at the head one cycle later; pop advances the head at the edge.
// Backpressure: none internally; the producer reserves a slot before requesting, so push never hits a full FIFO.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_dat,
  input  logic                   i_pop,
  output fetch_entry_t           o_head_dat,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop_ok;

  assign w_pop_ok   = i_pop && (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; a clear discards everything, including a same-cycle push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: fetches ARM words over req/ack, buffers them with their PC and presents them to decode; redirects flush stale fetches.
// Latency: request one edge after reset release; ack in cycle N gives instr_valid in cycle N+1; one idle cycle between ack and next request.
// Backpressure: a request is issued only while the FIFO has a free slot; decode stalls via instr_ready. Optional counters under FETCH_PERF_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc8,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_flushes
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_addr;
  fetch_entry_t  r_hold;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_dat;
  logic [CW-1:0] w_count;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_unused;

  // Low address bits of a redirect are ignored; targets are forced word aligned.
  assign w_unused   = ^branch_target[1:0];
  assign w_valid    = (w_count != '0);
  assign w_pop      = w_valid && instr_ready;
  assign w_push_dat = '{pc: r_addr, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (branch_taken),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  // Next-state and handshake decode; a redirect suppresses issue and discards any coincident ack.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      RUN: begin
        if (!branch_taken && (int'(w_count) < DEPTH)) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          w_push      = !branch_taken;
          w_state_nxt = RUN;
        end else if (branch_taken) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC and the held request address; r_addr stays stable while a request is outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      if (branch_taken) begin
        r_fetch_pc <= {branch_target[31:2], 2'b00};
      end else if (w_push) begin
        r_fetch_pc <= r_addr + PC_STEP;
      end
      if (w_issue) begin
        r_addr <= r_fetch_pc;
      end
    end
  end

  // Remember the last presented head so instr/instr_pc hold steady while the FIFO is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
    end else if (w_valid) begin
      r_hold <= w_head;
    end
  end

  assign imem_req    = (r_state != RUN);
  assign imem_addr   = r_addr;
  assign instr_valid = w_valid;
  assign instr       = w_valid ? w_head.instr : r_hold.instr;
  assign instr_pc    = w_valid ? w_head.pc    : r_hold.pc;
  assign instr_pc8   = instr_pc + ARM_PC_OFS;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetches;
  logic [31:0] r_perf_flushes;

  // Count words actually pushed and cycles spent redirecting; both wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetches <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetches <= r_perf_fetches + 32'd1;
      end
      if (branch_taken) begin
        r_perf_flushes <= r_perf_flushes + 32'd1;
      end
    end
  end

  assign perf_fetches = r_perf_fetches;
  assign perf_flushes = r_perf_flushes;
`else
  assign perf_fetches = 32'h0;
  assign perf_flushes = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responder, decode consumer and a scoreboard of {pc,instr}.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Ends with one summary line.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc8;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] perf_fetches;
  logic [31:0] perf_flushes;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc8     (instr_pc8),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .perf_fetches  (perf_fetches),
    .perf_flushes  (perf_flushes)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  localparam logic [31:0] DATA_KEY = 32'hE3A0_5000;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          n_accept = 0;
  int          n_flush = 0;
  int          age = 0;
  int          mem_lat = 1;
  bit          mem_en = 1'b0;
  bit          exp_flush = 1'b0;
  logic [31:0] exp_next = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, check any consumed head, update the model, advance.
  task automatic tick(output bit acked, output logic [31:0] ack_addr);
    exp_t e;
    exp_t ne;
    bit   req_before;
    req_before = imem_req;
    acked      = 1'b0;
    ack_addr   = imem_addr;
    if (mem_en && imem_req && age >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ DATA_KEY;
      acked      = 1'b1;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
    end
    if (instr_valid && instr_ready && !branch_taken) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow: observed valid head pc %h, expected no valid head", instr_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("head_instr", instr, e.instr);
        check("head_pc", instr_pc, e.pc);
        check("head_pc8", instr_pc8, e.pc + 32'd8);
      end
    end
    if (branch_taken) begin
      sb.delete();
      n_flush++;
      exp_next = {branch_target[31:2], 2'b00};
    end else if (acked && !exp_flush) begin
      ne.pc    = imem_addr;
      ne.instr = imem_rdata;
      sb.push_back(ne);
      n_accept++;
      exp_next = imem_addr + 32'd4;
    end
    if (acked) exp_flush = 1'b0;
    else if (branch_taken && imem_req) exp_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    age      = (acked || !req_before) ? 0 : age + 1;
    imem_ack = 1'b0;
  endtask

  task automatic run_until_ack(input string tag, output logic [31:0] a);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    a   = 32'h0;
    while (!got && n < 50) begin
      tick(got, a);
      n++;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_until_accepts(input int target);
    bit          g;
    logic [31:0] a;
    int          n;
    n = 0;
    while (n_accept < target && n < 400) begin
      tick(g, a);
      n++;
    end
    check("accept_budget", 32'(n_accept), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          g;
    bit          found;
    logic [31:0] a;
    logic [31:0] old;
    int          base;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_perf_f", perf_fetches, 32'h0);
    check("rst_perf_fl", perf_flushes, 32'h0);

    // 1: release, first edge requests RESET_PC; sequential addresses with 1-cycle memory
    reset = 1'b1;
    tick(g, a);
    check("t1_first_req", 32'(imem_req), 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    mem_en      = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_until_ack("t1", a);
      check("t1_addr", a, 32'(k * 4));
      check("t1_valid_n1", 32'(instr_valid), 32'd1);
      check("t1_idle_req", 32'(imem_req), 32'd0);
      if (k == 0) begin
        check("t1_head_pc", instr_pc, 32'h0);
        check("t1_head_pc8", instr_pc8, 32'h8);
      end
    end

    // Empty FIFO holds the last presented head
    mem_en = 1'b0;
    repeat (6) tick(g, a);
    check("hold_valid", 32'(instr_valid), 32'd0);
    check("hold_pc", instr_pc, exp_next - 32'd4);
    check("hold_instr", instr, (exp_next - 32'd4) ^ DATA_KEY);

    // 2: decode stalled -> exactly DEPTH words accepted, then no request until a pop
    instr_ready = 1'b0;
    mem_en      = 1'b1;
    base        = n_accept;
    repeat (30) tick(g, a);
    check("t2_accepts", 32'(n_accept - base), 32'd4);
    check("t2_req_full", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick(g, a);
    instr_ready = 1'b0;
    check("t2_req_pop_edge", 32'(imem_req), 32'd0);
    tick(g, a);
    check("t2_req_after_pop", 32'(imem_req), 32'd1);
    check("t2_addr_after_pop", imem_addr, exp_next);

    // 3: redirect while WAIT -> FLUSH, returning data dropped, refetch at aligned target
    mem_en      = 1'b0;
    instr_ready = 1'b1;
    repeat (8) tick(g, a);
    check("t3_req_wait", 32'(imem_req), 32'd1);
    check("t3_addr_wait", imem_addr, exp_next);
    old           = exp_next;
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    tick(g, a);
    branch_taken  = 1'b0;
    check("t3_valid_cleared", 32'(instr_valid), 32'd0);
    check("t3_req_held", 32'(imem_req), 32'd1);
    check("t3_addr_held", imem_addr, old);
    mem_en = 1'b1;
    run_until_ack("t3_flush", a);
    check("t3_flush_addr", a, old);
    check("t3_dropped", 32'(instr_valid), 32'd0);
    tick(g, a);
    check("t3_new_req", 32'(imem_req), 32'd1);
    check("t3_new_addr", imem_addr, 32'h100);
    run_until_ack("t3_target", a);
    check("t3_target_addr", a, 32'h100);
    check("t3_head_pc", instr_pc, 32'h100);
    tick(g, a);

    // 4: redirect coincident with ack -> data dropped, FIFO empty next cycle
    instr_ready = 1'b0;
    run_until_accepts(n_accept + 2);
    mem_en = 1'b0;
    repeat (3) tick(g, a);
    check("t4_valid_before", 32'(instr_valid), 32'd1);
    check("t4_req_before", 32'(imem_req), 32'd1);
    mem_en        = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick(g, a);
    branch_taken  = 1'b0;
    check("t4_valid_after", 32'(instr_valid), 32'd0);
    check("t4_req_after", 32'(imem_req), 32'd0);
    tick(g, a);
    check("t4_new_req", 32'(imem_req), 32'd1);
    check("t4_new_addr", imem_addr, 32'h200);

    // 5: PC wrap from 32'hFFFF_FFFC to 0; head pc8 wraps too
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    tick(g, a);
    branch_taken  = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found) begin
        run_until_ack("t5_top", a);
        if (a == 32'hFFFF_FFFC) found = 1'b1;
      end
    end
    check("t5_reached_top", 32'(found), 32'd1);
    check("t5_top_pc8", instr_pc8, 32'h4);
    run_until_ack("t5_wrap", a);
    check("t5_wrap_addr", a, 32'h0);
    repeat (3) tick(g, a);

    // 5b: reset asserted mid-WAIT -> outputs return to reset values immediately
    mem_en      = 1'b0;
    instr_ready = 1'b0;
    repeat (2) tick(g, a);
    check("t5_req_pending", 32'(imem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_req", 32'(imem_req), 32'd0);
    check("t5_rst_addr", imem_addr, 32'h0);
    check("t5_rst_valid", 32'(instr_valid), 32'd0);
    check("t5_rst_instr", instr, 32'h0);
    check("t5_rst_pc", instr_pc, 32'h0);
    check("t5_rst_perf", perf_fetches, 32'h0);
    sb.delete();
    exp_flush = 1'b0;
    exp_next  = 32'h0;
    age       = 0;
    n_accept  = 0;
    n_flush   = 0;
    repeat (2) tick(g, a);
    reset = 1'b1;
    tick(g, a);
    check("t5_rel_req", 32'(imem_req), 32'd1);
    check("t5_rel_addr", imem_addr, 32'h0);

    // 6: 10 accepted words and 2 redirects
    instr_ready = 1'b1;
    mem_en      = 1'b1;
    run_until_accepts(4);
    branch_taken  = 1'b1;
    branch_target = 32'h400;
    tick(g, a);
    branch_taken  = 1'b0;
    run_until_accepts(7);
    branch_taken  = 1'b1;
    branch_target = 32'h800;
    tick(g, a);
    branch_taken  = 1'b0;
    run_until_accepts(10);
    mem_en = 1'b0;
`ifdef FETCH_PERF_EN
    check("t6_perf_fetches", perf_fetches, 32'd10);
    check("t6_perf_flushes", perf_flushes, 32'd2);
`else
    check("t6_perf_fetches", perf_fetches, 32'd0);
    check("t6_perf_flushes", perf_flushes, 32'd0);
`endif

    // Drain: every accepted word was delivered
    repeat (10) tick(g, a);
    check("drain_sb_left", 32'(sb.size()), 32'd0);
    check("drain_valid", 32'(instr_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
